uart_tx: RTL and testbench

UART transmitter that serialises one byte per accepted request onto `tx_o`. It uses 8N1-style framing with optional even parity and 1 or 2 stop bits. It is the transmit-side companion of the UART receiver and shares its `baudrate_i`, `parity_en_i` and `stopbit_i` encoding, so both ends can be driven from one configuration register. It sits between the core's peripheral register file and the FPGA TX pin.

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry queue in front of the serialiser.
module uart_tx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        tx_o,
  output logic        busy_o,
  input  logic [15:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic [7:0]  shreg;
  logic [15:0] div;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic        par_en;
  logic        par_bit;
  logic        two_stop;
  logic        stop_idx;
  logic        ser_busy;

  logic        bit_done;
  logic        frame_end;
  logic        load;
  logic [7:0]  load_data;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  assign bit_done  = (cnt == '0);
  assign frame_end = (state == STOP) && bit_done && (!two_stop || stop_idx);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push      = tx_valid_i && !full;
  // Pop on the last stop-bit edge too, so queued frames run back-to-back.
  assign load      = (!ser_busy || frame_end) && !empty;
  assign load_data = mem[rd_ptr[AW-1:0]];
  assign busy_o    = full;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (load) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
`else
  assign load      = tx_valid_i && !ser_busy;
  assign load_data = tx_data_i;
  assign busy_o    = ser_busy;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      tx_o     <= 1'b1;
      ser_busy <= 1'b0;
      shreg    <= '0;
      div      <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
      stop_idx <= 1'b0;
    end else if (load) begin
      state    <= START;
      tx_o     <= 1'b0;
      ser_busy <= 1'b1;
      shreg    <= load_data;
      par_bit  <= ^load_data;
      div      <= (baudrate_i == '0) ? 16'd1 : baudrate_i;
      cnt      <= (baudrate_i == '0) ? 16'd0 : baudrate_i - 16'd1;
      bit_idx  <= '0;
      par_en   <= parity_en_i;
      two_stop <= stopbit_i;
      stop_idx <= 1'b0;
    end else if (state != IDLE) begin
      if (!bit_done) begin
        cnt <= cnt - 16'd1;
      end else begin
        cnt <= div - 16'd1;
        case (state)
          START: begin
            state <= DATA;
            tx_o  <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (par_en) begin
                state <= PARITY;
                tx_o  <= par_bit;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
          PARITY: begin
            state <= STOP;
            tx_o  <= 1'b1;
          end
          STOP: begin
            if (frame_end) begin
              state    <= IDLE;
              ser_busy <= 1'b0;
              cnt      <= '0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and random frames against a bit-list line model.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_o;
  logic        busy_o;
  logic [15:0] baudrate;
  logic        parity_en;
  logic        stopbit;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int vectors = 0;
  int miscompares = 0;

  // Line model: the active frame as a list of bits, each lasting cur_n cycles.
  int         rem = 0;
  int         cur_n = 1;
  int         cur_len = 0;
  bit         cur_bits[12];
  logic [7:0] q[$];

  uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .baudrate_i (baudrate),
    .parity_en_i(parity_en),
    .stopbit_i  (stopbit),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid)
  );

  always #5 clk = ~clk;

  function automatic bit model_busy();
`ifdef UART_TX_FIFO_EN
    return q.size() == DEPTH;
`else
    return rem > 0;
`endif
  endfunction

  function automatic int bit_pos();
    return (cur_len - rem) / cur_n;
  endfunction

  function automatic void start_frame(input logic [7:0] d);
    int nb;
    cur_n = (baudrate == 16'd0) ? 1 : int'(baudrate);
    cur_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) cur_bits[i+1] = d[i];
    nb = 9;
    if (parity_en) begin
      cur_bits[nb] = ^d;
      nb++;
    end
    cur_bits[nb] = 1'b1;
    nb++;
    if (stopbit) begin
      cur_bits[nb] = 1'b1;
      nb++;
    end
    cur_len = nb * cur_n;
    rem = cur_len;
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    bit   bp;
    logic etx;
    bp = model_busy();
    @(posedge clk);
    if (rem > 0) rem--;
`ifdef UART_TX_FIFO_EN
    if (rem == 0 && q.size() > 0) start_frame(q.pop_front());
    if (tx_valid && !bp) q.push_back(tx_data);
`else
    if (tx_valid && !bp) start_frame(tx_data);
`endif
    @(negedge clk);
    etx = (rem == 0) ? 1'b1 : cur_bits[bit_pos()];
    check("tx", tx_o, etx);
    check("busy", busy_o, model_busy());
  endtask

  task automatic drain(input int extra);
    int budget;
    budget = 3000;
    while ((rem > 0 || q.size() > 0) && budget > 0) begin
      tick();
      budget--;
    end
    vectors++;
    assert (budget > 0) else begin
      miscompares++;
      $error("FAIL drain_timeout got budget %0d expected >0", budget);
    end
    repeat (extra) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] b, input logic p, input logic s,
                      input int gap);
    tx_data   = d;
    baudrate  = b;
    parity_en = p;
    stopbit   = s;
    tx_valid  = 1'b1;
    tick();
    tx_valid  = 1'b0;
    drain(gap);
  endtask

  initial begin
    int  budget;
    bit  changed;
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    baudrate  = 16'd4;
    parity_en = 1'b0;
    stopbit   = 1'b0;
    @(negedge clk);
    check("reset_tx", tx_o, 1'b1);
    check("reset_busy", busy_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    send(8'hA5, 16'd4, 1'b0, 1'b0, 2);
    send(8'h07, 16'd3, 1'b1, 1'b1, 2);
    send(8'h03, 16'd3, 1'b1, 1'b1, 2);
    send(8'hFF, 16'd0, 1'b0, 1'b0, 2);
    send(8'hFF, 16'd1, 1'b0, 1'b0, 2);
    send(8'hFF, 16'd1, 1'b1, 1'b1, 0);

    // Inputs change during data bit 3 while valid stays high.
    tx_data   = 8'h5A;
    baudrate  = 16'd3;
    parity_en = 1'b0;
    stopbit   = 1'b0;
    tx_valid  = 1'b1;
    tick();
    changed = 1'b0;
    budget  = 500;
    while (rem > 0 && budget > 0) begin
      if (!changed && bit_pos() == 4) begin
        baudrate  = 16'd7;
        tx_data   = 8'hFF;
        parity_en = 1'b1;
        changed   = 1'b1;
      end
      tick();
      budget--;
    end
    tx_valid = 1'b0;
    drain(3);

    // Asynchronous reset during data bit 4.
    tx_data   = 8'hC3;
    baudrate  = 16'd4;
    parity_en = 1'b0;
    stopbit   = 1'b0;
    tx_valid  = 1'b1;
    tick();
    tx_valid = 1'b0;
    budget   = 200;
    while ((rem == 0 || bit_pos() < 5) && budget > 0) begin
      tick();
      budget--;
    end
    rst = 1'b1;
    #1;
    check("async_rst_tx", tx_o, 1'b1);
    check("async_rst_busy", busy_o, 1'b0);
    rem = 0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    send(8'h3C, 16'd4, 1'b0, 1'b0, 2);

`ifdef UART_TX_FIFO_EN
    // Fill the queue on consecutive cycles; the last byte arrives while full.
    baudrate  = 16'd2;
    parity_en = 1'b0;
    stopbit   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_data  = 8'(8'h11 * (i + 1));
      tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    drain(2);
`endif

    for (int k = 0; k < 24; k++) begin
      send(8'($urandom), 16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
